// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for an in-order pipeline.
// Tracks DEPTH in-flight producers and resolves rs/rt against them each cycle.

module fwd_resolve #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 1
) (
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH-1:0]        we,
  input  logic [DEPTH-1:0]        load,
  input  logic [DEPTH-1:0][4:0]   rd,
  input  logic [4:0]              src,
  input  logic                    used,
  input  logic [DEPTH*DATA_W-1:0] slot_data,
  output logic                    hit,
  output logic                    pend,
  output logic [1:0]              sel,
  output logic [DATA_W-1:0]       data
);
  logic       win_vld;
  logic [1:0] win;

  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (valid[i] && we[i] && rd[i] == src && src != 5'd0 && used) begin
        win_vld = 1'b1;
        win     = 2'(i);
      end
    end
    hit  = 1'b0;
    pend = 1'b0;
    sel  = 2'd0;
    data = '0;
    if (win_vld) begin
      if (load[win] && int'(win) < LOAD_RDY) begin
        pend = 1'b1;
      end else begin
        hit  = 1'b1;
        sel  = win;
        data = slot_data[win*DATA_W +: DATA_W];
      end
    end
  end
endmodule

module fwd_hazard_unit #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [4:0]              id_rs,
  input  logic [4:0]              id_rt,
  input  logic                    id_rs_used,
  input  logic                    id_rt_used,
  input  logic [4:0]              id_rd,
  input  logic                    id_we,
  input  logic                    id_load,
  input  logic [DEPTH*DATA_W-1:0] slot_data,
  output logic                    rs_hit,
  output logic                    rt_hit,
  output logic [DATA_W-1:0]       rs_data,
  output logic [DATA_W-1:0]       rt_data,
  output logic [1:0]              rs_sel,
  output logic [1:0]              rt_sel,
  output logic                    stall,
  output logic [15:0]             stall_cnt
);
  logic [DEPTH-1:0]      s_valid, s_we, s_load;
  logic [DEPTH-1:0][4:0] s_rd;

  // Operand 0 is rs, operand 1 is rt.
  logic [1:0][4:0]        src;
  logic [1:0]             used, hit, pend;
  logic [1:0][1:0]        sel;
  logic [1:0][DATA_W-1:0] data;

  assign src  = {id_rt, id_rs};
  assign used = {id_rt_used, id_rs_used};

  for (genvar op = 0; op < 2; op++) begin : g_op
    fwd_resolve #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)) u_res (
      .valid(s_valid), .we(s_we), .load(s_load), .rd(s_rd),
      .src(src[op]), .used(used[op]), .slot_data(slot_data),
      .hit(hit[op]), .pend(pend[op]), .sel(sel[op]), .data(data[op])
    );
  end

  assign rs_hit  = hit[0];
  assign rt_hit  = hit[1];
  assign rs_sel  = sel[0];
  assign rt_sel  = sel[1];
  assign rs_data = data[0];
  assign rt_data = data[1];
  assign stall   = id_valid & (|pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid   <= '0;
      s_we      <= '0;
      s_load    <= '0;
      s_rd      <= '0;
      stall_cnt <= 16'd0;
    end else if (flush) begin
      s_valid <= '0;
      s_we    <= '0;
      s_load  <= '0;
      s_rd    <= '0;
    end else begin
      for (int i = DEPTH-1; i >= 1; i--) begin
        s_valid[i] <= s_valid[i-1];
        s_we[i]    <= s_we[i-1];
        s_load[i]  <= s_load[i-1];
        s_rd[i]    <= s_rd[i-1];
      end
      // A stalled decode instruction re-presents next cycle; slot 0 gets a bubble.
      s_valid[0] <= stall ? 1'b0 : id_valid;
      s_we[0]    <= stall ? 1'b0 : id_we;
      s_load[0]  <= stall ? 1'b0 : id_load;
      s_rd[0]    <= stall ? 5'd0 : id_rd;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized checks of fwd_hazard_unit against a producer-history model.

module tb_fwd_hazard_unit;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 3;
  localparam int LOAD_RDY = 1;

  logic                    clk = 1'b0;
  logic                    rst_n, flush, id_valid, id_rs_used, id_rt_used, id_we, id_load;
  logic [4:0]              id_rs, id_rt, id_rd;
  logic [DEPTH*DATA_W-1:0] slot_data;
  logic                    rs_hit, rt_hit, stall;
  logic [DATA_W-1:0]       rs_data, rt_data;
  logic [1:0]              rs_sel, rt_sel;
  logic [15:0]             stall_cnt;
  logic [DATA_W-1:0]       sd [DEPTH];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  always_comb begin
    slot_data = '0;
    for (int i = 0; i < DEPTH; i++) slot_data[i*DATA_W +: DATA_W] = sd[i];
  end

  fwd_hazard_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .slot_data(slot_data),
    .rs_hit(rs_hit), .rt_hit(rt_hit), .rs_data(rs_data), .rt_data(rt_data),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  // Model: history of issued instructions, index 0 = most recent.
  typedef struct { bit v; int rd; bit we; bit ld; } ent_t;
  ent_t hist[$];
  int   m_cnt;

  function automatic void model_reset();
    ent_t z = '{v:0, rd:0, we:0, ld:0};
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(z);
    m_cnt = 0;
  endfunction

  function automatic void resolve(input int r, input bit u, output bit h, output int s,
                                  output bit p);
    h = 0; s = 0; p = 0;
    if (!u || r == 0) return;
    for (int i = 0; i < DEPTH; i++) begin
      if (hist[i].v && hist[i].we && hist[i].rd == r) begin
        if (hist[i].ld && i < LOAD_RDY) p = 1;
        else begin h = 1; s = i; end
        return;
      end
    end
  endfunction

  task automatic tick();
    bit h, p1, p2, st;
    int s;
    ent_t e, z;
    z = '{v:0, rd:0, we:0, ld:0};
    resolve(int'(id_rs), id_rs_used, h, s, p1);
    resolve(int'(id_rt), id_rt_used, h, s, p2);
    st = id_valid && (p1 || p2);
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (flush) begin
      for (int i = 0; i < DEPTH; i++) hist[i] = z;
    end else begin
      e = st ? z : '{v:id_valid, rd:int'(id_rd), we:id_we, ld:id_load};
      hist.push_front(e);
      void'(hist.pop_back());
      if (st && m_cnt < 65535) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drive(bit v, int rs, bit rsu, int rt, bit rtu, int rd, bit we, bit ld);
    id_valid = v; id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt); id_rt_used = rtu;
    id_rd = 5'(rd); id_we = we; id_load = ld; flush = 0;
  endtask

  task automatic clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic test_reset();
    drive(1, 3, 1, 3, 1, 3, 1, 0);
    tick(); tick();
    #1;
    vectors++;
    if ({rs_hit, rt_hit, stall, rs_sel, rt_sel} !== 7'd0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_outputs got hit=%b%b stall=%b sel=%0d/%0d cnt=%0d exp 0",
                         rs_hit, rt_hit, stall, rs_sel, rt_sel, stall_cnt);
    end
    vectors++;
    if (rs_data !== '0 || rt_data !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h exp 0", rs_data, rt_data);
    end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_alu_chain();
    drive(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    drive(1, 3, 1, 0, 0, 6, 1, 0);
    sd[0] = 32'h0000_00AA; sd[1] = 32'h1; sd[2] = 32'h2;
    #1;
    vectors++;
    if ({rs_hit, rs_sel, rs_data, stall} !== {1'b1, 2'd0, 32'h0000_00AA, 1'b0}) begin
      errors++; $display("FAIL alu_chain got hit=%b sel=%0d data=%h stall=%b exp 1/0/aa/0",
                         rs_hit, rs_sel, rs_data, stall);
    end
    tick();
  endtask

  task automatic test_priority();
    clear();
    drive(1, 0, 0, 0, 0, 5, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 9, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0); tick();
    drive(0, 9, 1, 5, 1, 0, 0, 0);
    sd[0] = 32'h11; sd[1] = 32'h22; sd[2] = 32'h33;
    #1;
    vectors++;
    if ({rt_hit, rt_sel, rt_data} !== {1'b1, 2'd0, 32'h11}) begin
      errors++; $display("FAIL priority_rt got hit=%b sel=%0d data=%h exp 1/0/11",
                         rt_hit, rt_sel, rt_data);
    end
    vectors++;
    if ({rs_hit, rs_sel, rs_data} !== {1'b1, 2'd1, 32'h22}) begin
      errors++; $display("FAIL priority_rs got hit=%b sel=%0d data=%h exp 1/1/22",
                         rs_hit, rs_sel, rs_data);
    end
    tick();
  endtask

  task automatic test_r0_unused();
    clear();
    drive(1, 0, 0, 0, 0, 0, 1, 1); tick();
    drive(1, 0, 1, 0, 1, 4, 1, 0);
    #1;
    vectors++;
    if ({rs_hit, rt_hit, stall} !== 3'b000) begin
      errors++; $display("FAIL r0_no_fwd got hit=%b%b stall=%b exp 000", rs_hit, rt_hit, stall);
    end
    tick();
    drive(1, 0, 0, 4, 0, 0, 0, 0);
    #1;
    vectors++;
    if (rt_hit !== 1'b0) begin
      errors++; $display("FAIL rt_unused got hit=%b exp 0", rt_hit);
    end
    id_rt_used = 1;
    #1;
    vectors++;
    if ({rt_hit, rt_sel} !== 3'b100) begin
      errors++; $display("FAIL rt_used got hit=%b sel=%0d exp 1/0", rt_hit, rt_sel);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear();
    drive(1, 0, 0, 0, 0, 7, 1, 1); tick();
    drive(1, 7, 1, 0, 0, 8, 1, 0);
    sd[0] = 32'h5; sd[1] = 32'hBEEF; sd[2] = 32'h6;
    #1;
    vectors++;
    if ({stall, rs_hit, stall_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      errors++; $display("FAIL load_use_stall got stall=%b hit=%b cnt=%0d exp 1/0/0",
                         stall, rs_hit, stall_cnt);
    end
    tick();
    #1;
    vectors++;
    if ({stall, rs_hit, rs_sel, rs_data, stall_cnt} !== {1'b0, 1'b1, 2'd1, 32'hBEEF, 16'd1}) begin
      errors++; $display("FAIL load_use_fwd got stall=%b hit=%b sel=%0d data=%h cnt=%0d exp 0/1/1/beef/1",
                         stall, rs_hit, rs_sel, rs_data, stall_cnt);
    end
    tick();
    drive(0, 8, 1, 0, 0, 0, 0, 0);
    #1;
    vectors++;
    if ({rs_hit, rs_sel} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL load_use_issue got hit=%b sel=%0d exp 1/0", rs_hit, rs_sel);
    end
    tick();
  endtask

  task automatic test_flush_stall();
    clear();
    drive(1, 0, 0, 0, 0, 7, 1, 1); tick();
    drive(1, 0, 0, 7, 1, 8, 1, 0);
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL flush_pre_stall got %b exp 1", stall);
    end
    flush = 1;
    tick();
    flush = 0;
    #1;
    vectors++;
    if ({rs_hit, rt_hit, stall, stall_cnt} !== {3'b000, 16'd1}) begin
      errors++; $display("FAIL flush_clear got hit=%b%b stall=%b cnt=%0d exp 000/1",
                         rs_hit, rt_hit, stall, stall_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    clear();
    drive(1, 0, 0, 0, 0, 7, 1, 1); tick();
    drive(1, 7, 1, 7, 1, 8, 1, 0);
    #1;
    vectors++;
    if ({stall, stall_cnt} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL areset_pre got stall=%b cnt=%0d exp 1/1", stall, stall_cnt);
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({stall, rs_hit, rt_hit, stall_cnt} !== {3'b000, 16'd0}) begin
      errors++; $display("FAIL areset_mid got stall=%b hit=%b%b cnt=%0d exp 000/0",
                         stall, rs_hit, rt_hit, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_random();
    bit hs, ht, ps, pt;
    int ss, st;
    logic [DATA_W-1:0] ds, dt;
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 6), $urandom_range(0, 1),
            $urandom_range(0, 6), $urandom_range(0, 1), $urandom_range(0, 6),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < DEPTH; i++) sd[i] = $urandom;
      resolve(int'(id_rs), id_rs_used, hs, ss, ps);
      resolve(int'(id_rt), id_rt_used, ht, st, pt);
      ds = hs ? sd[ss] : '0;
      dt = ht ? sd[st] : '0;
      #1;
      vectors++;
      if ({rs_hit, rs_sel, rs_data} !== {hs, 2'(ss), ds}) begin
        errors++; $display("FAIL rnd_rs c=%0d got %b/%0d/%h exp %b/%0d/%h",
                           c, rs_hit, rs_sel, rs_data, hs, ss, ds);
      end
      vectors++;
      if ({rt_hit, rt_sel, rt_data} !== {ht, 2'(st), dt}) begin
        errors++; $display("FAIL rnd_rt c=%0d got %b/%0d/%h exp %b/%0d/%h",
                           c, rt_hit, rt_sel, rt_data, ht, st, dt);
      end
      vectors++;
      if ({stall, stall_cnt} !== {id_valid && (ps || pt), 16'(m_cnt)}) begin
        errors++; $display("FAIL rnd_stall c=%0d got %b/%0d exp %b/%0d",
                           c, stall, stall_cnt, id_valid && (ps || pt), m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) sd[i] = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_alu_chain();
    test_priority();
    test_r0_unused();
    test_load_use();
    test_flush_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
